// File: rtl/axis_pattern_gen_pkg.sv
// Shared video-stream definitions: pattern mode encodings, FSM states,
// the colour-bar table and the {8'h00,R,G,B} pixel packing.
package axis_pattern_gen_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRID  = 2'd1,
    PAT_RAMP  = 2'd2,
    PAT_SOLID = 2'd3
  } pat_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LINE = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 24'hFFFFFF;
      3'd1:    bar_color = 24'hFFFF00;
      3'd2:    bar_color = 24'h00FFFF;
      3'd3:    bar_color = 24'h00FF00;
      3'd4:    bar_color = 24'hFF00FF;
      3'd5:    bar_color = 24'hFF0000;
      3'd6:    bar_color = 24'h0000FF;
      default: bar_color = 24'h000000;
    endcase
  endfunction

  function automatic logic [31:0] pack_pixel(input logic [23:0] rgb);
    pack_pixel = {8'h00, rgb};
  endfunction

endpackage

// File: rtl/axis_pattern_gen_pixel.sv
// Combinational pattern generator: maps (mode, x, y, bar index, solid colour)
// to a 24-bit RGB pixel.
module axis_pat_pixel
  import axis_pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE  = 480,
  parameter int V_ACTIVE  = 272,
  parameter int GRID_LOG2 = 4,
  parameter int XW        = 9,
  parameter int YW        = 9
) (
  input  logic [1:0]    mode,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [2:0]    bar_idx,
  input  logic [23:0]   rgb,
  output logic [23:0]   pixel
);

  // Masks wider than a counter simply truncate, reducing to a compare with 0.
  localparam logic [XW-1:0] X_MASK = XW'((1 << GRID_LOG2) - 1);
  localparam logic [YW-1:0] Y_MASK = YW'((1 << GRID_LOG2) - 1);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  logic [7:0] ramp;
  logic       grid_on;

  always_comb begin
    ramp    = 8'(x);
    grid_on = ((x & X_MASK) == '0) || ((y & Y_MASK) == '0) ||
              (x == X_LAST) || (y == Y_LAST);
    pixel   = 24'h000000;
    case (mode)
      PAT_BARS:  pixel = bar_color(bar_idx);
      PAT_GRID:  pixel = grid_on ? 24'hFFFFFF : 24'h000000;
      PAT_RAMP:  pixel = {ramp, ramp, ramp};
      PAT_SOLID: pixel = rgb;
      default:   pixel = 24'h000000;
    endcase
  end

endmodule

// File: rtl/axis_pattern_gen.sv
// AXI-Stream test-pattern video source: raster frames of H_ACTIVE x V_ACTIVE
// pixels with tuser on (0,0), tlast at end of line and LINE_GAP idle cycles.
module axis_pattern_gen
  import axis_pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE  = 480,
  parameter int V_ACTIVE  = 272,
  parameter int LINE_GAP  = 4,
  parameter int GRID_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic [3:0]  m_axis_tkeep,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [1:0]  fsm_state
);

  // Handshake: a beat moves on a rising edge with tvalid=1 and tready=1;
  // while tvalid=1 and tready=0 the beat is frozen, and tvalid only falls after a transfer.

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int GW = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;
  localparam int BW = H_ACTIVE / 8;

  localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
  localparam logic [XW-1:0] BW_LAST  = XW'(BW - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);

  state_t        state;
  logic [XW-1:0] x, bar_cnt, nx, nbar_cnt, pix_x;
  logic [YW-1:0] y, ny, pix_y;
  logic [2:0]    bar_idx, nbar_idx, pix_bar;
  logic [GW-1:0] gap_cnt;
  logic [1:0]    mode_q, pix_mode;
  logic [23:0]   rgb_q, pix_rgb, pixel;
  logic          last_x, last_y, relatch;

  // In LINE the pixel is built from the coordinates of the following beat;
  // in IDLE/GAP the stored (x,y) already name the beat about to be shown.
  always_comb begin
    last_x = (x == X_LAST);
    last_y = (y == Y_LAST);
    nx     = last_x ? '0 : x + 1'b1;
    ny     = last_x ? (last_y ? '0 : y + 1'b1) : y;
    if (last_x) begin
      nbar_idx = 3'd0;
      nbar_cnt = '0;
    end else if (bar_cnt == BW_LAST && bar_idx != 3'd7) begin
      nbar_idx = bar_idx + 3'd1;
      nbar_cnt = '0;
    end else begin
      nbar_idx = bar_idx;
      nbar_cnt = bar_cnt + 1'b1;
    end
    relatch  = (state == ST_IDLE) || (state == ST_LINE && last_x && last_y);
    pix_x    = (state == ST_LINE) ? nx : x;
    pix_y    = (state == ST_LINE) ? ny : y;
    pix_bar  = (state == ST_LINE) ? nbar_idx : bar_idx;
    pix_mode = relatch ? mode : mode_q;
    pix_rgb  = relatch ? solid_rgb : rgb_q;
  end

  axis_pat_pixel #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .GRID_LOG2(GRID_LOG2),
    .XW       (XW),
    .YW       (YW)
  ) u_pixel (
    .mode   (pix_mode),
    .x      (pix_x),
    .y      (pix_y),
    .bar_idx(pix_bar),
    .rgb    (pix_rgb),
    .pixel  (pixel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      x             <= '0;
      y             <= '0;
      bar_idx       <= 3'd0;
      bar_cnt       <= '0;
      gap_cnt       <= '0;
      mode_q        <= 2'd0;
      rgb_q         <= 24'h0;
      m_axis_tdata  <= 32'h0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_cnt     <= 16'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            mode_q        <= mode;
            rgb_q         <= solid_rgb;
            m_axis_tdata  <= pack_pixel(pixel);
            m_axis_tvalid <= 1'b1;
            m_axis_tuser  <= 1'b1;
            m_axis_tlast  <= 1'b0;
            state         <= ST_LINE;
          end
        end
        ST_LINE: begin
          if (m_axis_tvalid && m_axis_tready) begin
            x       <= nx;
            y       <= ny;
            bar_idx <= nbar_idx;
            bar_cnt <= nbar_cnt;
            m_axis_tuser <= 1'b0;
            m_axis_tlast <= 1'b0;
            if (last_x && last_y) begin
              frame_cnt <= frame_cnt + 16'd1;
              mode_q    <= mode;
              rgb_q     <= solid_rgb;
            end
            if (!last_x) begin
              m_axis_tdata <= pack_pixel(pixel);
              m_axis_tlast <= (nx == X_LAST);
            end else if (last_y && !enable) begin
              m_axis_tvalid <= 1'b0;
              state         <= ST_IDLE;
            end else if (LINE_GAP > 0) begin
              m_axis_tvalid <= 1'b0;
              gap_cnt       <= '0;
              state         <= ST_GAP;
            end else begin
              m_axis_tdata <= pack_pixel(pixel);
              m_axis_tuser <= last_y;
            end
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GAP_LAST) begin
            m_axis_tdata  <= pack_pixel(pixel);
            m_axis_tvalid <= 1'b1;
            m_axis_tuser  <= (x == '0) && (y == '0);
            m_axis_tlast  <= 1'b0;
            state         <= ST_LINE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign m_axis_tkeep = 4'hF;
  assign busy         = (state != ST_IDLE);
  assign fsm_state    = state;

endmodule
